decode_stage_pipe: RTL and testbench

Parametrised pipelined decode stage for the OTTER RV32I core. It sits between the IF/ID register and the EX stage and owns the register file with a write-back bypass. It decodes one instruction per cycle into a registered ID/EX bundle. It also detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush through a valid/ready handshake.

---
 rtl/otter_pipe_pkg.sv | 44 ++++
 rtl/decode_stage_pipe_if.sv | 58 +++++
 rtl/otter_regfile_bypass.sv | 44 ++++
 rtl/decode_stage_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_pipe_pkg.sv
// otter_pipe_pkg: opcodes, operand-select enums and control bundle
// shared by the OTTER decode stage and its register file.
package otter_pipe_pkg;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [3:0] ALU_LUI = 4'b1001;

  typedef enum logic {
    SRC_A_RS1,
    SRC_A_UIMM
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2,
    SRC_B_IIMM,
    SRC_B_SIMM,
    SRC_B_PC
  } alu_src_b_t;

  typedef enum logic [1:0] {
    WR_PC4,
    WR_CSR,
    WR_MEM,
    WR_ALU
  } rf_wr_sel_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [3:0] alu_fun;
    rf_wr_sel_t rf_wr_sel;
  } de_ctrl_t;

endpackage

// File: rtl/decode_stage_pipe_if.sv
// decode_stage_pipe_if: IF/ID input, write-back, EX handshake and ID/EX bundle.
// master = surrounding pipeline, slave = decode stage.
interface decode_stage_pipe_if #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);

  logic                   IF_VALID;
  logic [31:0]            IF_IR;
  logic [XLEN-1:0]        IF_PC;
  logic                   ID_READY;
  logic                   EX_READY;
  logic                   FLUSH;
  logic                   WB_WE;
  logic [REG_ADDR_W-1:0]  WB_RD;
  logic [XLEN-1:0]        WB_DATA;
  logic                   DE_VALID;
  logic [XLEN-1:0]        DE_PC;
  logic [XLEN-1:0]        DE_RS1;
  logic [XLEN-1:0]        DE_RS2;
  logic [XLEN-1:0]        DE_ALU_A;
  logic [XLEN-1:0]        DE_ALU_B;
  logic [XLEN-1:0]        DE_I_IMM;
  logic [XLEN-1:0]        DE_B_IMM;
  logic [XLEN-1:0]        DE_J_IMM;
  logic [31:0]            DE_IR;
  logic [REG_ADDR_W-1:0]  DE_RD;
  logic [REG_ADDR_W-1:0]  DE_RS1_ADDR;
  logic [REG_ADDR_W-1:0]  DE_RS2_ADDR;
  logic [3:0]             DE_ALU_FUN;
  logic [1:0]             DE_RF_WR_SEL;
  logic                   DE_REG_WRITE;
  logic                   DE_MEM_WRITE;
  logic                   DE_MEM_READ;
  logic [STALL_CNT_W-1:0] STALL_CNT;

  modport master (
    output IF_VALID, IF_IR, IF_PC, EX_READY, FLUSH,
    output WB_WE, WB_RD, WB_DATA,
    input  ID_READY, DE_VALID, DE_PC, DE_RS1, DE_RS2,
    input  DE_ALU_A, DE_ALU_B, DE_I_IMM, DE_B_IMM, DE_J_IMM,
    input  DE_IR, DE_RD, DE_RS1_ADDR, DE_RS2_ADDR,
    input  DE_ALU_FUN, DE_RF_WR_SEL,
    input  DE_REG_WRITE, DE_MEM_WRITE, DE_MEM_READ, STALL_CNT
  );

  modport slave (
    input  IF_VALID, IF_IR, IF_PC, EX_READY, FLUSH,
    input  WB_WE, WB_RD, WB_DATA,
    output ID_READY, DE_VALID, DE_PC, DE_RS1, DE_RS2,
    output DE_ALU_A, DE_ALU_B, DE_I_IMM, DE_B_IMM, DE_J_IMM,
    output DE_IR, DE_RD, DE_RS1_ADDR, DE_RS2_ADDR,
    output DE_ALU_FUN, DE_RF_WR_SEL,
    output DE_REG_WRITE, DE_MEM_WRITE, DE_MEM_READ, STALL_CNT
  );

endinterface

// File: rtl/otter_regfile_bypass.sv
// otter_regfile_bypass: 2R/1W register file, x0 hard-wired to zero.
// Ports: clk; we/wa/wd write port; ra1/ra2 -> rd1/rd2 combinational reads.
module otter_regfile_bypass #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [XLEN-1:0]       wd,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [XLEN-1:0]       rd1,
  output logic [XLEN-1:0]       rd2
);

  logic [XLEN-1:0] mem [2**REG_ADDR_W];
  logic            wr;

  assign wr = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wa] <= wd;
    end
  end

  // write-first: a same-cycle write is visible to the read
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (wr && wa == ra1) begin
      rd1 = wd;
    end
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (wr && wa == ra2) begin
      rd2 = wd;
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: OTTER RV32I decode stage with registered ID/EX bundle,
// load-use bubble insertion. Ports: CLK, RST (sync, high), bus (slave).
module decode_stage_pipe #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter bit HAZARD_EN   = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input logic                CLK,
  input logic                RST,
  decode_stage_pipe_if.slave bus
);

  import otter_pipe_pkg::*;

  logic [31:0]           ir;
  logic [6:0]            opc;
  logic [2:0]            f3;
  logic [REG_ADDR_W-1:0] rs1_a;
  logic [REG_ADDR_W-1:0] rs2_a;
  logic [REG_ADDR_W-1:0] rd_a;
  logic [XLEN-1:0]       rs1_v;
  logic [XLEN-1:0]       rs2_v;
  logic [XLEN-1:0]       i_imm;
  logic [XLEN-1:0]       s_imm;
  logic [XLEN-1:0]       b_imm;
  logic [XLEN-1:0]       u_imm;
  logic [XLEN-1:0]       j_imm;
  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  de_ctrl_t              ctrl;
  alu_src_a_t            src_a;
  alu_src_b_t            src_b;
  logic                  rs1_used;
  logic                  rs2_used;
  logic                  hold;
  logic                  hazard;
  logic                  take;
  logic                  kill;
  logic                  count;

  assign ir    = bus.IF_IR;
  assign opc   = ir[6:0];
  assign f3    = ir[14:12];
  assign rs1_a = REG_ADDR_W'(ir[19:15]);
  assign rs2_a = REG_ADDR_W'(ir[24:20]);
  assign rd_a  = REG_ADDR_W'(ir[11:7]);

  otter_regfile_bypass #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rf (
    .clk (CLK),
    .we  (bus.WB_WE),
    .wa  (bus.WB_RD),
    .wd  (bus.WB_DATA),
    .ra1 (rs1_a),
    .ra2 (rs2_a),
    .rd1 (rs1_v),
    .rd2 (rs2_v)
  );

  assign i_imm = {{(XLEN-11){ir[31]}}, ir[30:20]};
  assign s_imm = {{(XLEN-11){ir[31]}}, ir[30:25], ir[11:7]};
  assign b_imm = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25],
                  ir[11:8], 1'b0};
  assign u_imm = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};
  assign j_imm = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20],
                  ir[30:21], 1'b0};

  always_comb begin
    ctrl     = '0;
    src_a    = SRC_A_RS1;
    src_b    = SRC_B_RS2;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    unique case (1'b1)
      opc == LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_fun   = ALU_LUI;
        ctrl.rf_wr_sel = WR_ALU;
        src_a          = SRC_A_UIMM;
        rs1_used       = 1'b0;
      end
      opc == AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.rf_wr_sel = WR_ALU;
        src_a          = SRC_A_UIMM;
        src_b          = SRC_B_PC;
        rs1_used       = 1'b0;
      end
      opc == JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.rf_wr_sel = WR_PC4;
        rs1_used       = 1'b0;
      end
      opc == JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.rf_wr_sel = WR_PC4;
        src_b          = SRC_B_IIMM;
      end
      opc == BRANCH: begin
        rs2_used = 1'b1;
      end
      opc == LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.rf_wr_sel = WR_MEM;
        src_b          = SRC_B_IIMM;
      end
      opc == STORE: begin
        ctrl.mem_write = 1'b1;
        src_b          = SRC_B_SIMM;
        rs2_used       = 1'b1;
      end
      opc == OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.rf_wr_sel = WR_ALU;
        // only the shift-right pair uses bit 30 to pick SRA/SRL
        ctrl.alu_fun   = {(f3 == 3'b101) & ir[30], f3};
        src_b          = SRC_B_IIMM;
      end
      opc == OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.rf_wr_sel = WR_ALU;
        ctrl.alu_fun   = {ir[30], f3};
        rs2_used       = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_a = (src_a == SRC_A_UIMM) ? u_imm : rs1_v;

  always_comb begin
    unique case (src_b)
      SRC_B_RS2:  alu_b = rs2_v;
      SRC_B_IIMM: alu_b = i_imm;
      SRC_B_SIMM: alu_b = s_imm;
      SRC_B_PC:   alu_b = bus.IF_PC;
      default:    alu_b = rs2_v;
    endcase
  end

  assign hazard = HAZARD_EN && bus.DE_VALID
               && bus.DE_MEM_READ
               && (bus.DE_RD != '0) && bus.IF_VALID
               && ((rs1_used && rs1_a == bus.DE_RD)
                || (rs2_used && rs2_a == bus.DE_RD));
  assign hold   = bus.DE_VALID && !bus.EX_READY;
  assign take   = !bus.FLUSH && !hold && !hazard
               && bus.IF_VALID;
  // bubble on flush, on hazard, or when nothing arrives
  assign kill   = bus.FLUSH || (!hold && !take);
  assign count  = !bus.FLUSH && !hold && hazard
               && !(&bus.STALL_CNT);

  assign bus.ID_READY = bus.FLUSH || (!hold && !hazard);

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.DE_VALID     <= 1'b0;
      bus.DE_PC        <= '0;
      bus.DE_RS1       <= '0;
      bus.DE_RS2       <= '0;
      bus.DE_ALU_A     <= '0;
      bus.DE_ALU_B     <= '0;
      bus.DE_I_IMM     <= '0;
      bus.DE_B_IMM     <= '0;
      bus.DE_J_IMM     <= '0;
      bus.DE_IR        <= '0;
      bus.DE_RD        <= '0;
      bus.DE_RS1_ADDR  <= '0;
      bus.DE_RS2_ADDR  <= '0;
      bus.DE_ALU_FUN   <= '0;
      bus.DE_RF_WR_SEL <= '0;
      bus.DE_REG_WRITE <= 1'b0;
      bus.DE_MEM_WRITE <= 1'b0;
      bus.DE_MEM_READ  <= 1'b0;
      bus.STALL_CNT    <= '0;
    end else begin
      if (kill) begin
        bus.DE_VALID     <= 1'b0;
        bus.DE_REG_WRITE <= 1'b0;
        bus.DE_MEM_WRITE <= 1'b0;
        bus.DE_MEM_READ  <= 1'b0;
      end else if (take) begin
        bus.DE_VALID     <= 1'b1;
        bus.DE_PC        <= bus.IF_PC;
        bus.DE_RS1       <= rs1_v;
        bus.DE_RS2       <= rs2_v;
        bus.DE_ALU_A     <= alu_a;
        bus.DE_ALU_B     <= alu_b;
        bus.DE_I_IMM     <= i_imm;
        bus.DE_B_IMM     <= b_imm;
        bus.DE_J_IMM     <= j_imm;
        bus.DE_IR        <= ir;
        bus.DE_RD        <= rd_a;
        bus.DE_RS1_ADDR  <= rs1_a;
        bus.DE_RS2_ADDR  <= rs2_a;
        bus.DE_ALU_FUN   <= ctrl.alu_fun;
        bus.DE_RF_WR_SEL <= ctrl.rf_wr_sel;
        bus.DE_REG_WRITE <= ctrl.reg_write;
        bus.DE_MEM_WRITE <= ctrl.mem_write;
        bus.DE_MEM_READ  <= ctrl.mem_read;
      end
      if (count) begin
        bus.STALL_CNT <= bus.STALL_CNT + STALL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: two decode stages (XLEN=32 with hazard detection,
// XLEN=64 without) driven identically and checked against a reference model.
module tb_decode_stage_pipe;

  localparam bit [6:0] O_LUI = 7'h37;
  localparam bit [6:0] O_AUI = 7'h17;
  localparam bit [6:0] O_JAL = 7'h6f;
  localparam bit [6:0] O_JR  = 7'h67;
  localparam bit [6:0] O_BR  = 7'h63;
  localparam bit [6:0] O_LD  = 7'h03;
  localparam bit [6:0] O_ST  = 7'h23;
  localparam bit [6:0] O_IMM = 7'h13;
  localparam bit [6:0] O_OP  = 7'h33;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [63:0] if_pc;
  logic        ex_ready;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        chk_on = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  decode_stage_pipe_if #(.XLEN(32)) bus_a ();
  decode_stage_pipe_if #(.XLEN(64)) bus_b ();

  assign bus_a.IF_VALID = if_valid;
  assign bus_a.IF_IR    = if_ir;
  assign bus_a.IF_PC    = if_pc[31:0];
  assign bus_a.EX_READY = ex_ready;
  assign bus_a.FLUSH    = flush;
  assign bus_a.WB_WE    = wb_we;
  assign bus_a.WB_RD    = wb_rd;
  assign bus_a.WB_DATA  = wb_data[31:0];
  assign bus_b.IF_VALID = if_valid;
  assign bus_b.IF_IR    = if_ir;
  assign bus_b.IF_PC    = if_pc;
  assign bus_b.EX_READY = ex_ready;
  assign bus_b.FLUSH    = flush;
  assign bus_b.WB_WE    = wb_we;
  assign bus_b.WB_RD    = wb_rd;
  assign bus_b.WB_DATA  = wb_data;

  decode_stage_pipe #(
    .XLEN(32), .REG_ADDR_W(5),
    .HAZARD_EN(1'b1), .STALL_CNT_W(16)
  ) dut_a (
    .CLK(clk), .RST(rst), .bus(bus_a)
  );

  decode_stage_pipe #(
    .XLEN(64), .REG_ADDR_W(5),
    .HAZARD_EN(1'b0), .STALL_CNT_W(16)
  ) dut_b (
    .CLK(clk), .RST(rst), .bus(bus_b)
  );

  typedef struct {
    bit        v;
    longint    pc, rs1, rs2, a, b, ii, bi, ji;
    bit [31:0] ir;
    bit [4:0]  rd, r1a, r2a;
    bit [3:0]  fun;
    bit [1:0]  sel;
    bit        rw, mw, mr;
  } mde_t;

  mde_t   m [2];
  longint rf [2][32];
  int     scnt [2];
  bit     hz_en [2] = '{1'b1, 1'b0};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint msk(int k, longint x);
    return (k == 0) ? (x & 64'hFFFF_FFFF) : x;
  endfunction

  function automatic mde_t mzero();
    mde_t d;
    d.v = 0; d.pc = 0; d.rs1 = 0; d.rs2 = 0; d.a = 0; d.b = 0;
    d.ii = 0; d.bi = 0; d.ji = 0; d.ir = 0; d.rd = 0;
    d.r1a = 0; d.r2a = 0; d.fun = 0; d.sel = 0;
    d.rw = 0; d.mw = 0; d.mr = 0;
    return d;
  endfunction

  function automatic longint rdreg(int k, bit [4:0] r);
    if (r == 0) return 0;
    if (wb_we && wb_rd == r) return msk(k, wb_data);
    return rf[k][r];
  endfunction

  function automatic bit uses(bit [31:0] ir, bit [4:0] r);
    bit [6:0] op = ir[6:0];
    bit u1 = !(op inside {O_LUI, O_AUI, O_JAL});
    bit u2 = op inside {O_OP, O_ST, O_BR};
    return (u1 && ir[19:15] == r) || (u2 && ir[24:20] == r);
  endfunction

  function automatic bit hz(int k);
    return hz_en[k] && m[k].v && m[k].mr && m[k].rd != 0
        && if_valid && uses(if_ir, m[k].rd);
  endfunction

  function automatic mde_t dec(int k);
    mde_t     d = mzero();
    longint   s = longint'($signed(if_ir));
    bit [6:0] op = if_ir[6:0];
    bit [2:0] f3 = if_ir[14:12];
    longint   ui, si;
    int       sa = 0;
    int       sb = 0;
    d.v   = 1;
    d.ir  = if_ir;
    d.pc  = msk(k, if_pc);
    d.rd  = if_ir[11:7];
    d.r1a = if_ir[19:15];
    d.r2a = if_ir[24:20];
    d.rs1 = rdreg(k, d.r1a);
    d.rs2 = rdreg(k, d.r2a);
    d.ii  = msk(k, s >>> 20);
    si    = msk(k, ((s >>> 25) << 5) | longint'(if_ir[11:7]));
    d.bi  = msk(k, ((s >>> 31) << 12) | (longint'(if_ir[7]) << 11)
                 | (longint'(if_ir[30:25]) << 5)
                 | (longint'(if_ir[11:8]) << 1));
    ui    = msk(k, (s >>> 12) << 12);
    d.ji  = msk(k, ((s >>> 31) << 20) | (longint'(if_ir[19:12]) << 12)
                 | (longint'(if_ir[20]) << 11)
                 | (longint'(if_ir[30:21]) << 1));
    case (op)
      O_LUI: begin d.rw = 1; d.fun = 9; d.sel = 3; sa = 1; end
      O_AUI: begin d.rw = 1; d.sel = 3; sa = 1; sb = 3; end
      O_JAL: begin d.rw = 1; d.sel = 0; end
      O_JR:  begin d.rw = 1; d.sel = 0; sb = 1; end
      O_LD:  begin d.rw = 1; d.mr = 1; d.sel = 2; sb = 1; end
      O_ST:  begin d.mw = 1; sb = 2; end
      O_IMM: begin
        d.rw = 1; d.sel = 3; sb = 1;
        d.fun = {(f3 == 5) ? if_ir[30] : 1'b0, f3};
      end
      O_OP:  begin d.rw = 1; d.sel = 3; d.fun = {if_ir[30], f3}; end
      default: ;
    endcase
    d.a = (sa == 1) ? ui : d.rs1;
    case (sb)
      1: d.b = d.ii;
      2: d.b = si;
      3: d.b = d.pc;
      default: d.b = d.rs2;
    endcase
    return d;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m[k] <= mzero();
        scnt[k] <= 0;
      end else if (flush) begin
        m[k].v <= 0; m[k].rw <= 0; m[k].mw <= 0; m[k].mr <= 0;
      end else if (m[k].v && !ex_ready) begin
        m[k] <= m[k];
      end else if (hz(k)) begin
        m[k].v <= 0; m[k].rw <= 0; m[k].mw <= 0; m[k].mr <= 0;
        if (scnt[k] != 65535) scnt[k] <= scnt[k] + 1;
      end else if (if_valid) begin
        m[k] <= dec(k);
      end else begin
        m[k].v <= 0; m[k].rw <= 0; m[k].mw <= 0; m[k].mr <= 0;
      end
      if (wb_we && wb_rd != 0) rf[k][wb_rd] <= msk(k, wb_data);
    end
  end

  task automatic cmp_all(
    input int k, input logic v, rw, mw, mr, rdy,
    input logic [63:0] pc, rs1, rs2, a, b, ii, bi, ji,
    input logic [31:0] ir, input logic [4:0] rd, r1a, r2a,
    input logic [3:0] fun, input logic [1:0] sel,
    input logic [15:0] sc
  );
    string p = (k == 0) ? "a." : "b.";
    bit    er;
    er = flush || !((m[k].v && !ex_ready) || hz(k));
    chk({p, "valid"}, v, m[k].v);
    chk({p, "reg_write"}, rw, m[k].rw);
    chk({p, "mem_write"}, mw, m[k].mw);
    chk({p, "mem_read"}, mr, m[k].mr);
    chk({p, "id_ready"}, rdy, er);
    chk({p, "stall_cnt"}, sc, scnt[k]);
    if (m[k].v) begin
      chk({p, "pc"}, pc, m[k].pc);
      chk({p, "rs1"}, rs1, m[k].rs1);
      chk({p, "rs2"}, rs2, m[k].rs2);
      chk({p, "alu_a"}, a, m[k].a);
      chk({p, "alu_b"}, b, m[k].b);
      chk({p, "i_imm"}, ii, m[k].ii);
      chk({p, "b_imm"}, bi, m[k].bi);
      chk({p, "j_imm"}, ji, m[k].ji);
      chk({p, "ir"}, ir, m[k].ir);
      chk({p, "rd"}, rd, m[k].rd);
      chk({p, "rs1_addr"}, r1a, m[k].r1a);
      chk({p, "rs2_addr"}, r2a, m[k].r2a);
      chk({p, "alu_fun"}, fun, m[k].fun);
      chk({p, "rf_wr_sel"}, sel, m[k].sel);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_all(0, bus_a.DE_VALID, bus_a.DE_REG_WRITE,
        bus_a.DE_MEM_WRITE, bus_a.DE_MEM_READ, bus_a.ID_READY,
        64'(bus_a.DE_PC), 64'(bus_a.DE_RS1), 64'(bus_a.DE_RS2),
        64'(bus_a.DE_ALU_A), 64'(bus_a.DE_ALU_B),
        64'(bus_a.DE_I_IMM), 64'(bus_a.DE_B_IMM),
        64'(bus_a.DE_J_IMM), bus_a.DE_IR, bus_a.DE_RD,
        bus_a.DE_RS1_ADDR, bus_a.DE_RS2_ADDR,
        bus_a.DE_ALU_FUN, bus_a.DE_RF_WR_SEL, bus_a.STALL_CNT);
      cmp_all(1, bus_b.DE_VALID, bus_b.DE_REG_WRITE,
        bus_b.DE_MEM_WRITE, bus_b.DE_MEM_READ, bus_b.ID_READY,
        bus_b.DE_PC, bus_b.DE_RS1, bus_b.DE_RS2,
        bus_b.DE_ALU_A, bus_b.DE_ALU_B,
        bus_b.DE_I_IMM, bus_b.DE_B_IMM,
        bus_b.DE_J_IMM, bus_b.DE_IR, bus_b.DE_RD,
        bus_b.DE_RS1_ADDR, bus_b.DE_RS2_ADDR,
        bus_b.DE_ALU_FUN, bus_b.DE_RF_WR_SEL, bus_b.STALL_CNT);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_ir();
    logic [31:0] r = $urandom;
    int          c = $urandom_range(0, 12);
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    case (c)
      0: r[6:0] = O_LUI;
      1: r[6:0] = O_AUI;
      2: r[6:0] = O_JAL;
      3: r[6:0] = O_JR;
      4: r[6:0] = O_BR;
      5: r[6:0] = O_ST;
      6: r[6:0] = O_IMM;
      7, 8: r[6:0] = O_OP;
      9, 10, 11: r[6:0] = O_LD;
      default: ;
    endcase
    return r;
  endfunction

  localparam logic [31:0] ADDI = 32'h00708113;
  localparam logic [31:0] ADD3 = 32'h001081B3;
  localparam logic [31:0] ADD4 = 32'h00000233;
  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] ADD6 = 32'h00228333;

  initial begin
    logic consumed;
    rst = 1; if_valid = 1; if_ir = ADDI; if_pc = 0;
    ex_ready = 1; flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    tick();
    chk_on = 1;
    tick();
    rst = 0; if_valid = 0;
    #1;
    chk("rst.valid", bus_a.DE_VALID, 1'b0);
    chk("rst.reg_write", bus_a.DE_REG_WRITE, 1'b0);
    chk("rst.mem_read", bus_a.DE_MEM_READ, 1'b0);
    chk("rst.stall_cnt", bus_a.STALL_CNT, 0);
    chk("rst.ir", bus_a.DE_IR, 0);
    chk("rst.id_ready", bus_a.ID_READY, 1'b1);

    for (int r = 0; r < 32; r++) begin
      wb_we = 1;
      wb_rd = 5'(r);
      wb_data = (r == 0) ? 64'hFFFF : (r == 1) ? 64'd5 :
                {$urandom, $urandom};
      tick();
    end
    wb_we = 0;

    if_valid = 1; if_ir = ADDI; if_pc = 64'h40;
    tick();
    chk("addi.rs1", bus_a.DE_RS1, 5);
    chk("addi.alu_a", bus_a.DE_ALU_A, 5);
    chk("addi.alu_b", bus_a.DE_ALU_B, 7);
    chk("addi.rd", bus_a.DE_RD, 2);
    chk("addi.reg_write", bus_a.DE_REG_WRITE, 1'b1);
    chk("addi.pc", bus_a.DE_PC, 32'h40);

    if_ir = ADD3; wb_we = 1; wb_rd = 1; wb_data = 9;
    tick();
    chk("byp.rs1", bus_a.DE_RS1, 9);
    chk("byp.rs2", bus_a.DE_RS2, 9);
    if_ir = ADD4; wb_rd = 0; wb_data = 64'hFFFF;
    tick();
    chk("x0.bypass", bus_a.DE_RS1, 0);
    wb_we = 0;
    tick();
    chk("x0.stored", bus_a.DE_RS2, 0);

    if_ir = LW5;
    tick();
    chk("lw.mem_read", bus_a.DE_MEM_READ, 1'b1);
    if_ir = ADD6;
    #1;
    chk("lu.id_ready_a", bus_a.ID_READY, 1'b0);
    chk("lu.id_ready_b", bus_b.ID_READY, 1'b1);
    tick();
    chk("lu.bubble", bus_a.DE_VALID, 1'b0);
    chk("lu.stall_cnt", bus_a.STALL_CNT, 1);
    chk("lu.nohz_ir", bus_b.DE_IR, ADD6);
    #1;
    chk("lu.ready_after", bus_a.ID_READY, 1'b1);
    tick();
    chk("lu.captured", bus_a.DE_IR, ADD6);
    chk("lu.valid", bus_a.DE_VALID, 1'b1);

    ex_ready = 0; if_ir = ADDI;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.id_ready", bus_a.ID_READY, 1'b0);
      tick();
      chk("bp.ir", bus_a.DE_IR, ADD6);
      chk("bp.valid", bus_a.DE_VALID, 1'b1);
    end
    flush = 1;
    #1;
    chk("fl.id_ready", bus_a.ID_READY, 1'b1);
    tick();
    chk("fl.valid", bus_a.DE_VALID, 1'b0);
    flush = 0; ex_ready = 1;

    if_ir = LW5;
    tick();
    if_ir = ADD6; flush = 1;
    tick();
    chk("flhz.stall_cnt", bus_a.STALL_CNT, 1);
    chk("flhz.valid", bus_a.DE_VALID, 1'b0);
    flush = 0;

    if_ir = 32'hFFDFF0EF;
    tick();
    chk("jal.j_imm64", bus_b.DE_J_IMM, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jal.j_imm32", bus_a.DE_J_IMM, 32'hFFFF_FFFC);
    if_ir = 32'h800000B7;
    tick();
    chk("lui.alu_a64", bus_b.DE_ALU_A, 64'hFFFF_FFFF_8000_0000);
    chk("lui.alu_a32", bus_a.DE_ALU_A, 32'h8000_0000);

    for (int i = 0; i < 3000; i++) begin
      #1;
      consumed = bus_a.ID_READY || !if_valid;
      tick();
      if (consumed) begin
        if_valid = ($urandom_range(0, 99) < 85);
        if_ir = rnd_ir();
        if_pc = {$urandom, $urandom} & ~64'h3;
      end
      ex_ready = ($urandom_range(0, 99) < 80);
      flush = ($urandom_range(0, 99) < 5);
      wb_we = $urandom_range(0, 1) == 1;
      wb_rd = 5'($urandom_range(0, 9));
      wb_data = {$urandom, $urandom};
      rst = (i == 1500);
    end
    rst = 0;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
